// File: rtl/fifo_sync_v2.sv
// fifo_sync_v2: valid/ready FIFO with any depth, threshold flags, flush and an
// optional output register stage (FIFO_SYNC_V2_OUT_REG_EN).
module fifo_sync_v2 #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, mem_rd;
  assign count        = count_q;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign in_ready     = !full && !rst && !flush;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready && !flush;
`ifdef FIFO_SYNC_V2_OUT_REG_EN
  // The output register is one of the DEPTH entries; memory holds count - ov.
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  assign mem_rd    = (count_q != CW'(ov_q)) && (!ov_q || pop);
  assign out_valid = ov_q && !rst;
  assign out_data  = od_q;
  always_comb begin
    ov_d = mem_rd ? 1'b1 : (pop ? 1'b0 : ov_q);
    od_d = mem_rd ? mem_q[rd_ptr_q] : od_q;
  end
  always_ff @(posedge clk) begin
    ov_q <= (rst || flush) ? 1'b0 : ov_d;
    od_q <= od_d;
  end
`else
  assign mem_rd    = pop;
  assign out_valid = !empty && !rst;
  assign out_data  = mem_q[rd_ptr_q];
`endif
  always_comb begin
    wr_ptr_d = push ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = mem_rd ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : ((pop && !push) ? count_q - 1'b1 : count_q);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_fifo_sync_v2.sv
// tb_fifo_sync_v2: scoreboard bench for fifo_sync_v2 with DEPTH=5, WIDTH=32.
module tb_fifo_sync_v2;
  localparam int DEPTH = 5;
`ifdef FIFO_SYNC_V2_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, full, empty, almost_full, almost_empty;
  logic [31:0] out_data;
  logic [2:0] count;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  logic [31:0] e;
  bit pu, po;
  logic [31:0] pd;

  fifo_sync_v2 #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count)
  );

  always #5 clk = ~clk;

  // Drives one cycle, reports the handshakes seen before the edge; records accepted pushes.
  task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit fl,
                     output bit pushed, output bit popped, output logic [31:0] pdata);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #2;
    pushed = iv && in_ready;
    popped = out_valid && ordy && !fl;
    pdata = out_data;
    if (pushed) q.push_back(d);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    cyc(0, 0, 0, 0, pu, po, pd);
    cyc(1, 1, 1, 0, pu, po, pd);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_err++; $display("FAIL rst_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
    n_cmp++; if (pu !== 1'b0) begin n_err++; $display("FAIL rst_push got %b exp 0", pu); end
    q.delete();
    rst = 0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 32'(i), 0, 0, pu, po, pd);
      n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 3)) begin n_err++; $display("FAIL fill_af got %b at count %0d", almost_full, i + 1); end
      n_cmp++; if (almost_empty !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_ae got %b at count %0d", almost_empty, i + 1); end
    end
    n_cmp++; if ({full, in_ready} !== 2'b10) begin n_err++; $display("FAIL fill_full got full=%b in_ready=%b exp 1/0", full, in_ready); end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      cyc(0, 0, 1, 0, pu, po, pd);
      if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL fill_pop got %h exp %h", pd, e); end end
    end
    n_cmp++; if (q.size() != 0 || empty !== 1'b1) begin n_err++; $display("FAIL fill_drain left %0d empty=%b exp 0/1", q.size(), empty); end
  endtask

  task automatic test_latency;
    cyc(1, 32'hC0DE, 0, 0, pu, po, pd);
    n_cmp++; if (out_valid !== (LAT == 1)) begin n_err++; $display("FAIL lat_cycle1 out_valid got %b exp %b", out_valid, LAT == 1); end
    cyc(0, 0, 0, 0, pu, po, pd);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_cycle2 out_valid got %b exp 1", out_valid); end
    cyc(0, 0, 1, 0, pu, po, pd);
    n_cmp++; e = q.pop_front(); if (po !== 1'b1 || pd !== e) begin n_err++; $display("FAIL lat_pop got %b/%h exp 1/%h", po, pd, e); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 32'hA0 + 32'(i), 0, 0, pu, po, pd);
      for (int k = 0; k < 4 && q.size() > 0; k++) begin
        cyc(0, 0, 1, 0, pu, po, pd);
        if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL wrap_pop got %h exp %h", pd, e); end end
      end
    end
    n_cmp++; if (q.size() != 0 || count !== 3'd0) begin n_err++; $display("FAIL wrap_end left %0d count %0d exp 0", q.size(), count); end
  endtask

  task automatic test_full_boundary;
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h100 + 32'(i), 0, 0, pu, po, pd);
    cyc(0, 0, 0, 0, pu, po, pd);
    cyc(1, 32'hBEEF, 1, 0, pu, po, pd);
    n_cmp++; if ({pu, po} !== 2'b01) begin n_err++; $display("FAIL fb_handshake got push=%b pop=%b exp 0/1", pu, po); end
    if (po) begin e = q.pop_front(); n_cmp++; if (pd !== e) begin n_err++; $display("FAIL fb_pop got %h exp %h", pd, e); end end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fb_count got %0d exp 4", count); end
    cyc(1, 32'hBEEF, 0, 0, pu, po, pd);
    n_cmp++; if (pu !== 1'b1 || count !== 3'd5) begin n_err++; $display("FAIL fb_refill got push=%b count=%0d exp 1/5", pu, count); end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      cyc(0, 0, 1, 0, pu, po, pd);
      if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL fb_drain got %h exp %h", pd, e); end end
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i), 0, 0, pu, po, pd);
    cyc(1, 32'h77, 1, 1, pu, po, pd);
    n_cmp++; if (pu !== 1'b0) begin n_err++; $display("FAIL flush_push got %b exp 0", pu); end
    q.delete();
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_state got count=%0d empty=%b exp 0/1", count, empty); end
    cyc(1, 32'h55, 0, 0, pu, po, pd);
    for (int k = 0; k < 6 && q.size() > 0; k++) begin
      cyc(0, 0, 1, 0, pu, po, pd);
      if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL flush_pop got %h exp %h", pd, e); end end
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL flush_drain left %0d exp 0", q.size()); end
  endtask

  task automatic test_midrun_reset;
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i), 0, 0, pu, po, pd);
    rst = 1; #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b00) begin n_err++; $display("FAIL mrst_during got ov=%b ir=%b exp 0/0", out_valid, in_ready); end
    cyc(1, 32'h9, 1, 0, pu, po, pd);
    cyc(1, 32'h9, 1, 0, pu, po, pd);
    n_cmp++; if ({pu, po} !== 2'b00) begin n_err++; $display("FAIL mrst_handshake got push=%b pop=%b exp 0/0", pu, po); end
    rst = 0; q.delete(); #1;
    n_cmp++; if (count !== 3'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_after got count=%0d ir=%b exp 0/1", count, in_ready); end
    cyc(1, 32'h1234, 0, 0, pu, po, pd);
    for (int k = 0; k < 6 && q.size() > 0; k++) begin
      cyc(0, 0, 1, 0, pu, po, pd);
      if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL mrst_pop got %h exp %h", pd, e); end end
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL mrst_drain left %0d exp 0", q.size()); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 2000; c++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0, pu, po, pd);
      if (po) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_pop got %h exp no data", pd); end
        else begin e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL rnd_pop got %h exp %h", pd, e); end end
      end
      n_cmp++; if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        n_err++; $display("FAIL rnd_state got count=%0d full=%b empty=%b exp count=%0d", count, full, empty, q.size());
      end
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      cyc(0, 0, 1, 0, pu, po, pd);
      if (po) begin n_cmp++; e = q.pop_front(); if (pd !== e) begin n_err++; $display("FAIL rnd_drain got %h exp %h", pd, e); end end
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_end left %0d exp 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_wrap();
    test_full_boundary();
    test_flush();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_sync_v2.md
# fifo_sync_v2

Parametrised synchronous valid/ready FIFO, successor to `fifo_sync`. It adds:
- arbitrary (non-power-of-two) depth,
- programmable almost-full/almost-empty flags,
- a synchronous flush,
- an optional registered output stage.

It sits between any two valid/ready stages in the same clock domain and replaces `fifo_sync` wherever threshold flags or flushing are needed.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 16, storage entries (≥2, any integer)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- CW (localparam), $clog2(DEPTH+1), count width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous clear of contents
- in_valid  in  1  producer has data
- in_ready  out  1  FIFO accepts data
- in_data  in  WIDTH  write data
- out_valid  out  1  FIFO has data
- out_ready  in  1  consumer accepts data
- out_data  out  WIDTH  read data, head of queue
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- Push when in_valid && in_ready.
- Pop when out_valid && out_ready.
- in_ready = !full && !rst && !flush.
- out_valid = !empty (base build).
- No pass-through: a push into an empty FIFO is not visible on out_valid in the same cycle.
- No push when full, even if a pop occurs in the same cycle. in_ready depends only on the registered count.
- Simultaneous push and pop (0 < count < DEPTH): count unchanged; both pointers advance.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly. No power-of-two masking.
- count arithmetic: +1 on push only, −1 on pop only, unchanged otherwise. It never leaves 0..DEPTH.
- out_data is undefined (don't-care) while out_valid=0. Bench compares data only on pop.
- flush=1 at a clock edge:
  - wr_ptr, rd_ptr and count go to 0.
  - Any handshake in that cycle is discarded: in_ready=0, and out_valid's pop is not counted.
  - Memory contents are not cleared.
- rst has priority over flush.
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, out_valid=0, in_ready=0 while rst=1.
- Reset mid-operation: all stored data is lost. in_ready rises in the first cycle with rst=0.
- Flag outputs are combinational from the registered count. They change only in the cycle after the handshake that modifies count.

## Timing
- Push→out_valid latency, empty FIFO: 1 cycle (base), 2 cycles (with output register).
- Throughput: one push and one pop per cycle, sustained, at any occupancy 0 < count < DEPTH.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid are held stable.
- The FIFO requires upstream to hold in_data while in_valid && !in_ready.
- full→not-full: in_ready rises the cycle after the first pop from full.

## Configuration
- Macro FIFO_SYNC_V2_OUT_REG_EN.
- Defined:
  - out_data and out_valid come from a register stage fed from memory.
  - The output stage counts as one of the DEPTH entries, and count includes it. Total capacity stays DEPTH.
  - The output register refills from memory in the same cycle it is popped; no bubble when memory holds data.
  - flush and rst clear its valid bit.
  - First-word latency 2 cycles.
- Undefined: out_data = mem[rd_ptr] combinationally; first-word latency 1 cycle.
- The flag and count semantics above are identical in both builds.

## Test plan
- Reset then fill: WIDTH=32, DEPTH=5; push 0..4 with out_ready=0 → count=5, full=1, in_ready=0, almost_full from count=3; pop all → 0,1,2,3,4 in order, empty=1.
- Wrap: DEPTH=5; 12 iterations of push-then-pop, values 0xA0+i → every pop matches in order; rd_ptr/wr_ptr pass index 4→0 twice without error.
- Full boundary: full FIFO, in_valid=1 and out_ready=1 in the same cycle → one pop, no push, count=4; the next cycle's push is accepted, count=5.
- Flush: 3 entries, flush=1 for one cycle with in_valid=1 → count=0, empty=1, the concurrent push is lost; next push 0x55 pops as 0x55.
- Mid-run reset: 4 entries, rst=1 for 2 cycles → out_valid=0, in_ready=0 during rst, count=0 after; a subsequent push/pop of 0x1234 is correct.
- Random: 2000 cycles, 50% in_valid/out_ready, checked against a queue model → zero mismatches. Run in both FIFO_SYNC_V2_OUT_REG_EN builds, with first-word latency 1 vs 2 cycles checked.
